// File: rtl/draw_source_arbiter.sv
// -----------------------------------------------------------------------------
// draw_source_arbiter
//
// Composes one frame from all draw sources on the shared draw-manager bus.
// On frame_start, each source is selected in SOURCE_ID order (0 first), the
// arbiter waits for its write burst, and accepted pixels become linear
// framebuffer writes (fb_addr = y*DRAW_WIDTH + x). Sources drawn later overwrite
// earlier ones, so source 0 is the background.
//
// Ports:
//   clk, resetN           clock, synchronous active-low reset
//   frame_start           one-cycle pulse: back buffer free, start composing
//   write_source_sel      currently selected source
//   write_awaited         waiting for the selected source to start its burst
//   write_active          selected source drives a valid pixel this cycle
//   write_color_data      pixel colour
//   write_transparent     pixel must not be written
//   write_x_addr/_y_addr  pixel coordinates
//   fb_we/fb_addr/fb_data framebuffer write port (1-cycle write latency)
//   busy                  compose in progress
//   compose_done          one-cycle pulse after the last source
//   skipped               sticky per-frame timeout flags, one bit per source
//   overrun               sticky: frame_start arrived while busy
//   clipped               (DRAW_ARB_CLIP_EN only) sticky per-frame flag: an
//                         out-of-range pixel was suppressed
//
// Optional feature macro: DRAW_ARB_CLIP_EN
//   defined   -> out-of-range pixels are suppressed and flagged on 'clipped'
//   undefined -> no range check; out-of-range pixels alias in fb_addr
// -----------------------------------------------------------------------------
module draw_source_arbiter #(
   parameter int NUM_SOURCES       = 4,
   parameter int SOURCE_SEL_ADDRW  = 2,
   parameter int DRAW_WIDTH        = 160,
   parameter int DRAW_HEIGHT       = 120,
   parameter int DRAW_WIDTH_ADDRW  = 8,
   parameter int DRAW_HEIGHT_ADDRW = 7,
   parameter int COLOR_DEPTH       = 9,
   parameter int FB_ADDRW          = 15,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input  logic                          clk,
   input  logic                          resetN,
   input  logic                          frame_start,
   output logic [SOURCE_SEL_ADDRW-1:0]   write_source_sel,
   output logic                          write_awaited,
   input  logic                          write_active,
   input  logic [COLOR_DEPTH-1:0]        write_color_data,
   input  logic                          write_transparent,
   input  logic [DRAW_WIDTH_ADDRW-1:0]   write_x_addr,
   input  logic [DRAW_HEIGHT_ADDRW-1:0]  write_y_addr,
   output logic                          fb_we,
   output logic [FB_ADDRW-1:0]           fb_addr,
   output logic [COLOR_DEPTH-1:0]        fb_data,
   output logic                          busy,
   output logic                          compose_done,
   output logic [NUM_SOURCES-1:0]        skipped,
   output logic                          overrun
`ifdef DRAW_ARB_CLIP_EN
   ,output logic                         clipped
`endif
);

   localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   // Parameter sanity checks at elaboration time.
   if ((2 ** SOURCE_SEL_ADDRW) < NUM_SOURCES) begin : g_bad_sel_w
      $error("SOURCE_SEL_ADDRW too narrow for NUM_SOURCES");
   end
   if ((2 ** FB_ADDRW) < (DRAW_WIDTH * DRAW_HEIGHT)) begin : g_bad_fb_w
      $error("FB_ADDRW too narrow for DRAW_WIDTH*DRAW_HEIGHT");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_SELECT,
      S_AWAIT,
      S_WRITE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                        r_state;
   logic [SOURCE_SEL_ADDRW-1:0]   r_sel;
   logic [TO_W-1:0]               r_to_cnt;
   logic                          r_awaited;
   logic                          r_busy;
   logic                          r_compose_done;
   logic [NUM_SOURCES-1:0]        r_skipped;
   logic                          r_overrun;
   logic                          r_fb_we;
   logic [FB_ADDRW-1:0]           r_fb_addr;
   logic [COLOR_DEPTH-1:0]        r_fb_data;

   logic                          w_accept;
   logic                          w_write;
   logic [FB_ADDRW-1:0]           w_pix_addr;

   // A pixel is accepted in AWAIT (first pixel of the burst) and in WRITE.
   // Bus data is only looked at when write_active=1; otherwise it may be 'z.
   assign w_accept   = ((r_state == S_AWAIT) || (r_state == S_WRITE)) && write_active;
   assign w_pix_addr = FB_ADDRW'(write_y_addr) * FB_ADDRW'(DRAW_WIDTH) + FB_ADDRW'(write_x_addr);

`ifdef DRAW_ARB_CLIP_EN
   logic r_clipped;
   logic w_in_range;
   logic w_clip_hit;

   assign w_in_range = (32'(write_x_addr) < 32'(DRAW_WIDTH)) &&
                       (32'(write_y_addr) < 32'(DRAW_HEIGHT));
   assign w_clip_hit = w_accept && !write_transparent && !w_in_range;
   assign w_write    = w_accept && !write_transparent && w_in_range;
   assign clipped    = r_clipped;

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_clipped <= 1'b0;
      end else if ((r_state == S_IDLE) && frame_start) begin
         r_clipped <= 1'b0;
      end else if (w_clip_hit) begin
         r_clipped <= 1'b1;
      end
   end
`else
   // Without clipping, range is the sources' responsibility (transparent flag).
   assign w_write = w_accept && !write_transparent;
`endif

   always_ff @(posedge clk) begin
      if (!resetN) begin
         r_state        <= S_IDLE;
         r_sel          <= '0;
         r_to_cnt       <= '0;
         r_awaited      <= 1'b0;
         r_busy         <= 1'b0;
         r_compose_done <= 1'b0;
         r_skipped      <= '0;
         r_overrun      <= 1'b0;
         r_fb_we        <= 1'b0;
         r_fb_addr      <= '0;
         r_fb_data      <= '0;
      end else begin
         // Write pipeline: one register stage between bus and framebuffer.
         r_fb_we <= w_write;
         if (w_write) begin
            r_fb_addr <= w_pix_addr;
            r_fb_data <= write_color_data;
         end

         r_compose_done <= 1'b0;

         // frame_start outside IDLE (including the DONE cycle) is dropped.
         if (frame_start && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (frame_start) begin
                  r_state   <= S_SELECT;
                  r_sel     <= '0;
                  r_skipped <= '0;
                  r_busy    <= 1'b1;
               end
            end

            // One settle cycle with the new select and write_awaited low.
            S_SELECT: begin
               r_state   <= S_AWAIT;
               r_awaited <= 1'b1;
               r_to_cnt  <= '0;
            end

            S_AWAIT: begin
               if (write_active) begin
                  r_state   <= S_WRITE;
                  r_awaited <= 1'b0;
               end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  r_skipped[r_sel] <= 1'b1;
                  r_awaited        <= 1'b0;
                  r_state          <= S_NEXT;
               end else begin
                  r_to_cnt <= r_to_cnt + TO_W'(1);
               end
            end

            // Burst length is unbounded; it ends on the first idle cycle.
            S_WRITE: begin
               if (!write_active) begin
                  r_state <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (r_sel == SOURCE_SEL_ADDRW'(NUM_SOURCES - 1)) begin
                  r_state        <= S_DONE;
                  r_compose_done <= 1'b1;
               end else begin
                  r_sel   <= r_sel + SOURCE_SEL_ADDRW'(1);
                  r_state <= S_SELECT;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_sel   <= '0;
            end

            default: begin
               r_state   <= S_IDLE;
               r_busy    <= 1'b0;
               r_awaited <= 1'b0;
               r_sel     <= '0;
            end
         endcase
      end
   end

   assign write_source_sel = r_sel;
   assign write_awaited    = r_awaited;
   assign busy             = r_busy;
   assign compose_done     = r_compose_done;
   assign skipped          = r_skipped;
   assign overrun          = r_overrun;
   assign fb_we            = r_fb_we;
   assign fb_addr          = r_fb_addr;
   assign fb_data          = r_fb_data;

endmodule

// File: tb/tb_draw_source_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for draw_source_arbiter with NUM_SOURCES=2.
// The reference model works at pixel level: every non-transparent pixel handed
// to the bus is expected on the framebuffer port one cycle later at
// (y*DRAW_WIDTH + x) mod 2^FB_ADDRW, and a frame's write count, skip mask and
// sticky flags are predicted from the stimulus alone.
// -----------------------------------------------------------------------------
module tb_draw_source_arbiter;

   localparam int NS  = 2;
   localparam int SW  = 1;
   localparam int DW  = 160;
   localparam int DH  = 120;
   localparam int CD  = 9;
   localparam int FAW = 15;
   localparam int TO  = 4096;

   logic            clk;
   logic            resetN;
   logic            frame_start;
   logic [SW-1:0]   write_source_sel;
   logic            write_awaited;
   logic            write_active;
   logic [CD-1:0]   write_color_data;
   logic            write_transparent;
   logic [7:0]      write_x_addr;
   logic [6:0]      write_y_addr;
   logic            fb_we;
   logic [FAW-1:0]  fb_addr;
   logic [CD-1:0]   fb_data;
   logic            busy;
   logic            compose_done;
   logic [NS-1:0]   skipped;
   logic            overrun;
`ifdef DRAW_ARB_CLIP_EN
   logic            clipped;
`endif

   draw_source_arbiter #(
      .NUM_SOURCES(NS), .SOURCE_SEL_ADDRW(SW), .DRAW_WIDTH(DW), .DRAW_HEIGHT(DH),
      .DRAW_WIDTH_ADDRW(8), .DRAW_HEIGHT_ADDRW(7), .COLOR_DEPTH(CD),
      .FB_ADDRW(FAW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .resetN(resetN), .frame_start(frame_start),
      .write_source_sel(write_source_sel), .write_awaited(write_awaited),
      .write_active(write_active), .write_color_data(write_color_data),
      .write_transparent(write_transparent), .write_x_addr(write_x_addr),
      .write_y_addr(write_y_addr), .fb_we(fb_we), .fb_addr(fb_addr),
      .fb_data(fb_data), .busy(busy), .compose_done(compose_done),
      .skipped(skipped), .overrun(overrun)
`ifdef DRAW_ARB_CLIP_EN
      , .clipped(clipped)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int exp_wr;
   int obs_wr;
   bit exp_overrun;
   bit exp_clipped;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: does an accepted pixel reach the framebuffer?
   function automatic bit exp_write(input int x, input int y, input bit tr);
`ifdef DRAW_ARB_CLIP_EN
      return !tr && (x < DW) && (y < DH);
`else
      return !tr;
`endif
   endfunction

   // One bus cycle. act=1 only while the arbiter is known to accept pixels.
   task automatic drive_pix(input bit act, input bit tr, input int x, input int y, input int col);
      if (act) begin
         write_active      = 1'b1;
         write_transparent = tr;
         write_x_addr      = x[7:0];
         write_y_addr      = y[6:0];
         write_color_data  = col[CD-1:0];
      end else begin
         write_active      = 1'b0;
         write_transparent = 1'bz;
         write_x_addr      = 'z;
         write_y_addr      = 'z;
         write_color_data  = 'z;
      end
      tick();
      if (fb_we === 1'b1) obs_wr++;
      if (act && exp_write(x, y, tr)) begin
         exp_wr++;
         chk("fb_we", fb_we, 1);
         chk("fb_addr", fb_addr, (y * DW + x) % (1 << FAW));
         chk("fb_data", fb_data, col % (1 << CD));
      end else begin
         chk("fb_we_quiet", fb_we, 0);
      end
      if (act && !tr && ((x >= DW) || (y >= DH))) exp_clipped = 1'b1;
   endtask

   task automatic idle();
      drive_pix(0, 0, 0, 0, 0);
   endtask

   task automatic start_frame();
      exp_wr      = 0;
      obs_wr      = 0;
      exp_clipped = 1'b0;
      frame_start = 1'b1;
      idle();
      frame_start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_skipped_clear", skipped, 0);
`ifdef DRAW_ARB_CLIP_EN
      chk("start_clipped_clear", clipped, 0);
`endif
   endtask

   task automatic wait_awaited(input int s);
      bit seen = 1'b0;
      for (int i = 0; i < 16 && !seen; i++) begin
         idle();
         if (write_awaited === 1'b1) seen = 1'b1;
      end
      chk("await_seen", seen, 1);
      chk("await_sel", write_source_sel, s);
   endtask

   // Source that never answers: write_awaited must stay high TO cycles.
   task automatic timeout_src();
      int cnt = 1;
      for (int i = 0; i < TO + 100; i++) begin
         idle();
         if (write_awaited === 1'b1) cnt++;
         else break;
      end
      chk("timeout_len", cnt, TO);
   endtask

   task automatic rand_burst();
      int n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
         drive_pix(1, ($urandom_range(0, 3) == 0), $urandom_range(0, DW - 1),
                   $urandom_range(0, DH - 1), $urandom_range(0, (1 << CD) - 1));
      end
      idle();
   endtask

   task automatic finish_frame(input int exp_skip, input bit fs_at_done);
      bit seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         idle();
         if (compose_done === 1'b1) seen = 1'b1;
      end
      chk("done_seen", seen, 1);
      chk("done_busy", busy, 1);
      if (fs_at_done) begin
         frame_start = 1'b1;
         exp_overrun = 1'b1;
      end
      idle();
      frame_start = 1'b0;
      chk("done_pulse", compose_done, 0);
      chk("done_idle", busy, 0);
      chk("done_sel", write_source_sel, 0);
      chk("done_skipped", skipped, exp_skip);
      chk("frame_writes", obs_wr, exp_wr);
      chk("overrun", overrun, exp_overrun);
`ifdef DRAW_ARB_CLIP_EN
      chk("clipped", clipped, exp_clipped);
`endif
      if (fs_at_done) begin
         for (int i = 0; i < 4; i++) idle();
         chk("no_restart", busy, 0);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      resetN      = 1'b0;
      frame_start = 1'b0;
      exp_overrun = 1'b0;
      exp_clipped = 1'b0;
      exp_wr      = 0;
      obs_wr      = 0;
      for (int i = 0; i < 3; i++) idle();
      chk("rst_fb_we", fb_we, 0);
      chk("rst_fb_addr", fb_addr, 0);
      chk("rst_fb_data", fb_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", compose_done, 0);
      chk("rst_skipped", skipped, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_awaited", write_awaited, 0);
      chk("rst_sel", write_source_sel, 0);
      resetN = 1'b1;
      idle();

      // Directed: three pixels then a one-pixel source.
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 1, 0, 9'h011);
      drive_pix(1, 0, 2, 1, 9'h022);
      drive_pix(1, 0, 159, 119, 9'h1FF);
      idle();
      wait_awaited(1);
      drive_pix(1, 0, 7, 3, 9'h0AA);
      idle();
      finish_frame(0, 0);

      // Transparent second pixel of four; source 1 is a zero-pixel source.
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 10, 20, 9'h101);
      drive_pix(1, 1, 11, 20, 9'h102);
      drive_pix(1, 0, 12, 20, 9'h103);
      drive_pix(1, 0, 13, 20, 9'h104);
      idle();
      wait_awaited(1);
      drive_pix(1, 1, 0, 0, 0);
      idle();
      finish_frame(0, 0);
      chk("transp_count", obs_wr, 3);

      // Source 1 times out; next frame_start clears the flags.
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 5, 5, 9'h055);
      idle();
      wait_awaited(1);
      timeout_src();
      finish_frame(2, 0);
      start_frame();
      wait_awaited(0);
      rand_burst();
      wait_awaited(1);
      rand_burst();
      finish_frame(0, 0);

      // frame_start coinciding with compose_done: overrun, no new compose.
      start_frame();
      wait_awaited(0);
      rand_burst();
      wait_awaited(1);
      rand_burst();
      finish_frame(0, 1);

      // Reset in the middle of a burst.
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 10, 10, 9'h0F0);
      drive_pix(1, 0, 11, 10, 9'h0F1);
      resetN            = 1'b0;
      write_active      = 1'b1;
      write_transparent = 1'b0;
      write_x_addr      = 8'd12;
      write_y_addr      = 7'd10;
      write_color_data  = 9'h0F2;
      tick();
      chk("rst_mid_fb_we", fb_we, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_sel", write_source_sel, 0);
      chk("rst_mid_awaited", write_awaited, 0);
      chk("rst_mid_overrun", overrun, 0);
      exp_overrun = 1'b0;
      resetN = 1'b1;
      idle();
      idle();
      chk("rst_mid_still_idle", busy, 0);
      start_frame();
      wait_awaited(0);
      rand_burst();
      wait_awaited(1);
      rand_burst();
      finish_frame(0, 0);

      // frame_start while busy: overrun set, compose unaffected.
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 30, 40, 9'h033);
      drive_pix(1, 0, 31, 40, 9'h034);
      drive_pix(1, 0, 32, 40, 9'h035);
      idle();
      frame_start = 1'b1;
      exp_overrun = 1'b1;
      idle();
      frame_start = 1'b0;
      chk("overrun_mid", overrun, 1);
      wait_awaited(1);
      drive_pix(1, 0, 50, 60, 9'h1A0);
      drive_pix(1, 0, 51, 60, 9'h1A1);
      idle();
      finish_frame(0, 0);
      chk("overrun_count", obs_wr, 5);

      // Out-of-range pixel: clipped (feature on) or aliased to 1000 (off).
      start_frame();
      wait_awaited(0);
      drive_pix(1, 0, 200, 5, 9'h0C3);
      idle();
      wait_awaited(1);
      drive_pix(1, 1, 0, 0, 0);
      idle();
      finish_frame(0, 0);

      // Randomised frames.
      for (int f = 0; f < 8; f++) begin
         start_frame();
         wait_awaited(0);
         rand_burst();
         wait_awaited(1);
         rand_burst();
         finish_frame(0, 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
